// File: rtl/brush_painter.sv
// brush_painter: writes a square brush in raster order, one pixel per wr_en&&wr_ready; first pixel the cycle after start.
// Define BRUSH_CLIP_EN to skip off-screen pixels instead of letting coordinates wrap.
module brush_painter #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int BRUSH_MAX   = 8,
  parameter int COLOR_WIDTH = 3,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [X_WIDTH-1:0]     x_in,
  input  logic [Y_WIDTH-1:0]     y_in,
  input  logic [3:0]             size,
  input  logic [COLOR_WIDTH-1:0] color,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_en,
  output logic [X_WIDTH-1:0]     wr_x,
  output logic [Y_WIDTH-1:0]     wr_y,
  output logic [COLOR_WIDTH-1:0] wr_color,
  input  logic                   wr_ready
);

`ifdef BRUSH_CLIP_EN
  localparam int XS_W = X_WIDTH + 1;
  localparam int YS_W = Y_WIDTH + 1;
`else
  localparam int XS_W = X_WIDTH;
  localparam int YS_W = Y_WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PAINT, S_DONE} state_t;

  state_t                 state_q;
  logic [X_WIDTH-1:0]     x0_q;
  logic [Y_WIDTH-1:0]     y0_q;
  logic [3:0]             side_q, dx_q, dy_q;
  logic [COLOR_WIDTH-1:0] color_q;

  logic [3:0]      side_d, dx_d, dy_d;
  logic [XS_W-1:0] sum_x;
  logic [YS_W-1:0] sum_y;
  logic            pix_ok, adv, row_end, last;

  always_comb begin
    side_d = size;
    if (size == 4'd0) begin
      side_d = 4'd1;
    end else if (size > 4'(BRUSH_MAX)) begin
      side_d = 4'(BRUSH_MAX);
    end

    sum_x = XS_W'(x0_q) + XS_W'(dx_q);
    sum_y = YS_W'(y0_q) + YS_W'(dy_q);
`ifdef BRUSH_CLIP_EN
    pix_ok = (sum_x < XS_W'(SCREEN_W)) && (sum_y < YS_W'(SCREEN_H));
`else
    pix_ok = 1'b1;
`endif

    // skipped pixels advance the counters as though the frame buffer took them
    adv     = (state_q == S_PAINT) && (wr_ready || !pix_ok);
    row_end = (dx_q == side_q - 4'd1);
    last    = row_end && (dy_q == side_q - 4'd1);
    dx_d    = row_end ? 4'd0 : dx_q + 4'd1;
    dy_d    = row_end ? dy_q + 4'd1 : dy_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      side_q  <= 4'd1;
      dx_q    <= '0;
      dy_q    <= '0;
      color_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x0_q    <= x_in;
            y0_q    <= y_in;
            side_q  <= side_d;
            color_q <= color;
            dx_q    <= '0;
            dy_q    <= '0;
            state_q <= (color == COLOR_NONE) ? S_DONE : S_PAINT;
          end
        end
        S_PAINT: begin
          if (adv) begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            if (last) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_en    = (state_q == S_PAINT) && pix_ok;
  assign wr_x     = sum_x[X_WIDTH-1:0];
  assign wr_y     = sum_y[Y_WIDTH-1:0];
  assign wr_color = color_q;

endmodule

// File: tb/tb_brush_painter.sv
// Directed bench: stimulus pushes expected writes/done cycles; a negedge monitor pops and compares.
module tb_brush_painter;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 3;
  localparam logic [CW-1:0] C_NONE  = 3'd0;
  localparam logic [CW-1:0] C_RED   = 3'd1;
  localparam logic [CW-1:0] C_GREEN = 3'd2;
  localparam logic [CW-1:0] C_BLUE  = 3'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x_in = '0;
  logic [YW-1:0] y_in = '0;
  logic [3:0]    size = '0;
  logic [CW-1:0] color = '0;
  logic          busy, done, wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [CW-1:0] wr_color;
  logic          wr_ready = 1'b1;

  brush_painter #(
    .SCREEN_W(640), .SCREEN_H(480), .X_WIDTH(XW), .Y_WIDTH(YW),
    .BRUSH_MAX(8), .COLOR_WIDTH(CW), .COLOR_NONE(C_NONE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .size(size), .color(color), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } wexp_t;

  wexp_t wq[$];
  int    dq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    lo_a = 1000000;
  int    lo_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // wr_ready is low across the absolute window [lo_a, lo_b]
  always @(posedge clk) begin
    #1;
    wr_ready = !(cyc >= lo_a && cyc <= lo_b);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_w(input int x, input int y, input int c, input int t);
    wexp_t e;
    e.x = x; e.y = y; e.c = c; e.t = t;
    wq.push_back(e);
  endtask

  task automatic push_sq(input int x, input int y, input int side, input int c, input int n);
    int k = 0;
    for (int j = 0; j < side; j++) begin
      for (int i = 0; i < side; i++) begin
        push_w(x + i, y + j, c, n + 1 + k);
        k++;
      end
    end
    dq.push_back(n + 1 + side * side);
  endtask

  // Monitor: stability under backpressure, write scoreboard, done timing.
  logic          hold_v = 1'b0;
  logic [XW-1:0] hold_x;
  logic [YW-1:0] hold_y;
  logic [CW-1:0] hold_c;

  always @(negedge clk) begin
    wexp_t e;
    if (hold_v) begin
      chk("hold_en", int'(wr_en), 1);
      chk("hold_xyc", {wr_x, wr_y, wr_color}, {hold_x, hold_y, hold_c});
    end
    hold_v = wr_en && !wr_ready;
    hold_x = wr_x; hold_y = wr_y; hold_c = wr_color;

    if (wr_en && wr_ready) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_x", int'(wr_x), -1);
      end else begin
        e = wq.pop_front();
        chk("wr_x", int'(wr_x), e.x);
        chk("wr_y", int'(wr_y), e.y);
        chk("wr_color", int'(wr_color), e.c);
        chk("wr_cycle", cyc, e.t);
      end
    end

    if (done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done_cycle", cyc, -1);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
        chk("writes_left_at_done", wq.size(), 0);
      end
    end
  end

  task automatic issue(input int x, input int y, input int s, input logic [CW-1:0] c,
                       output int n);
    @(posedge clk); #1;
    start = 1'b1; x_in = XW'(x); y_in = YW'(y); size = 4'(s); color = c;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((wq.size() != 0 || dq.size() != 0) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk({name, "_drain_left"}, wq.size() + dq.size(), 0);
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_outs", {wr_x, wr_y, wr_color}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic 2x2 red at (10,20)
    issue(10, 20, 2, C_RED, n);
    push_w(10, 20, C_RED, n + 1);
    push_w(11, 20, C_RED, n + 2);
    push_w(10, 21, C_RED, n + 3);
    push_w(11, 21, C_RED, n + 4);
    dq.push_back(n + 5);
    repeat (4) @(posedge clk);
    #1;
    chk("basic_busy_c5", int'(busy), 1);
    @(posedge clk); #1;
    chk("basic_busy_c6", int'(busy), 0);
    drain("basic", 20);

    // backpressure in cycles 2-3
    issue(10, 20, 2, C_RED, n);
    lo_a = n + 2; lo_b = n + 3;
    push_w(10, 20, C_RED, n + 1);
    push_w(11, 20, C_RED, n + 4);
    push_w(10, 21, C_RED, n + 5);
    push_w(11, 21, C_RED, n + 6);
    dq.push_back(n + 7);
    drain("bp", 30);
    lo_a = 1000000; lo_b = 0;

    // transparent brush, then an immediate blue 1x1 in cycle 2
    issue(50, 60, 3, C_NONE, n);
    dq.push_back(n + 1);
    issue(7, 8, 1, C_BLUE, n2);
    chk("b2b_start_cycle", n2, n + 2);
    push_w(7, 8, C_BLUE, n2 + 1);
    dq.push_back(n2 + 2);
    drain("none", 20);

    // size 0 -> one pixel
    issue(33, 44, 0, C_GREEN, n);
    push_w(33, 44, C_GREEN, n + 1);
    dq.push_back(n + 2);
    drain("size0", 20);

    // size 15 clamps to 8x8
    issue(100, 50, 15, C_BLUE, n);
    push_sq(100, 50, 8, C_BLUE, n);
    drain("size15", 120);

    // start and input changes during PAINT are ignored
    issue(200, 100, 3, C_GREEN, n);
    push_sq(200, 100, 3, C_GREEN, n);
    @(posedge clk); #1;
    start = 1'b1; x_in = 10'd5; y_in = 9'd5; size = 4'd2; color = C_BLUE;
    @(posedge clk); #1;
    start = 1'b0;
    drain("ignore_start", 30);

    // bottom-right corner
    issue(639, 479, 2, C_RED, n);
`ifdef BRUSH_CLIP_EN
    push_w(639, 479, C_RED, n + 1);
    dq.push_back(n + 5);
`else
    push_w(639, 479, C_RED, n + 1);
    push_w(640, 479, C_RED, n + 2);
    push_w(639, 480, C_RED, n + 3);
    push_w(640, 480, C_RED, n + 4);
    dq.push_back(n + 5);
`endif
    drain("corner", 20);

    // reset in the middle of a 4x4 brush: two writes, then nothing
    issue(300, 200, 4, C_RED, n);
    push_w(300, 200, C_RED, n + 1);
    push_w(301, 200, C_RED, n + 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_outs", {wr_x, wr_y, wr_color}, 0);
    chk("midrst_writes_seen", wq.size(), 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_quiet_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/brush_painter.md
# brush_painter

Downstream consumer of the color selector. On a paint request, it writes a square brush of pixels in the currently selected color into the frame-buffer write port, one pixel per accepted handshake. Order is raster order: x fastest, then y. `COLOR_NONE` is a transparent brush, so a request with that color completes with no writes.

## Interface

Parameters:
- `SCREEN_W`, 640: visible width in pixels
- `SCREEN_H`, 480: visible height in pixels
- `X_WIDTH`, 10: x coordinate width
- `Y_WIDTH`, 9: y coordinate width
- `BRUSH_MAX`, 8: largest brush side in pixels

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high reset
- `start` in 1: paint request, sampled in IDLE only
- `x_in` in `X_WIDTH`: brush top-left x
- `y_in` in `Y_WIDTH`: brush top-left y
- `size` in 4: brush side length
- `color` in `COLOR_WIDTH`: selected color, driven by the color selector
- `busy` out 1: high in PAINT and DONE
- `done` out 1: one-cycle completion pulse
- `wr_en` out 1: pixel write valid
- `wr_x` out `X_WIDTH`: pixel x
- `wr_y` out `Y_WIDTH`: pixel y
- `wr_color` out `COLOR_WIDTH`: pixel color
- `wr_ready` in 1: frame buffer accepts the write on this edge

## Operation

- FSM states are IDLE, PAINT and DONE. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `wr_x`=0, `wr_y`=0, `wr_color`=0. Internal `dx`/`dy` counters are 0.
- IDLE with `start`=1:
  - Latch `x_in`, `y_in` and `color`.
  - Latch the effective size: `size`=0 becomes 1, and `size`>`BRUSH_MAX` becomes `BRUSH_MAX`.
  - Clear `dx`/`dy`.
  - Go to PAINT, or straight to DONE if the latched color is `COLOR_NONE`.
- `start` outside IDLE is ignored and not queued. Changes to `color`, `x_in`, `y_in` or `size` after the latch have no effect on the brush in progress.
- PAINT drives the current pixel:
  - `wr_x` = x0+`dx` and `wr_y` = y0+`dy`, each truncated to its port width.
  - `wr_color` = the latched color.
  - `wr_en`=1.
- A pixel is consumed on an edge where `wr_en`&&`wr_ready`. Then:
  - `dx` increments.
  - At `dx`=side-1, `dx` wraps to 0 and `dy` increments.
  - At `dx`=`dy`=side-1, the FSM goes to DONE.
- While `wr_ready`=0, `wr_en`, `wr_x`, `wr_y` and `wr_color` hold stable.
- DONE asserts `done`=1 and `wr_en`=0 for exactly one cycle, then returns to IDLE.
- Reset mid-operation aborts immediately. No further writes occur and `done` is not pulsed.

## Timing

- The `start` edge is cycle 0. PAINT runs from cycle 1, and the first `wr_en` is in cycle 1.
- With `wr_ready` held at 1, an N×N brush writes in cycles 1..N², and `done` is in cycle N²+1.
- Each cycle with `wr_ready`=0 delays completion by one cycle.
- A `COLOR_NONE` request has `done` in cycle 1 and no writes.
- In the cycle after `done`, the FSM is in IDLE and accepts a new `start`. That gives a back-to-back rate of one brush per N²+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `wr_ready` to `wr_en`.

## Configuration

- `BRUSH_CLIP_EN` defined:
  - Pixels with x0+`dx` ≥ `SCREEN_W` or y0+`dy` ≥ `SCREEN_H` are skipped. Each skipped pixel still costs one PAINT cycle, with `wr_en`=0 and the counters advancing as if accepted.
  - Sums are computed one bit wider before the compare, so there is no wrap.
- `BRUSH_CLIP_EN` undefined:
  - All N² pixels are emitted.
  - Coordinates wrap modulo 2^`X_WIDTH` and 2^`Y_WIDTH`.
  - Off-screen handling is the frame buffer's responsibility.

## Test plan

- Reset: assert `reset` mid-PAINT of a 4×4 brush → next cycle `busy`=0, `wr_en`=0, `done`=0, outputs 0. No write or `done` follows within 20 cycles.
- Basic brush:
  - Stimulus: `start` with `x_in`=10, `y_in`=20, `size`=2, `color`=`COLOR_RED`, `wr_ready`=1.
  - Required writes: (10,20), (11,20), (10,21), (11,21), in cycles 1–4, all with `wr_color`=`COLOR_RED`.
  - Then `done` in cycle 5, and `busy` low in cycle 6.
- Backpressure: same brush with `wr_ready`=0 in cycles 2–3 → (11,20) held stable in cycles 2–4. All 4 writes complete, `done` in cycle 7.
- Transparent brush: `color`=`COLOR_NONE`, `size`=3 → zero writes, `done` in cycle 1. A second `start` with `color`=`COLOR_BLUE` in cycle 2 is accepted.
- Size edge cases:
  - `size`=0 → exactly one write at (x0,y0).
  - `size`=15 with `BRUSH_MAX`=8 → exactly 64 writes.
  - `start` pulsed during PAINT → ignored, write count unchanged.
- Clipping: (639,479), `size`=2:
  - With `BRUSH_CLIP_EN`: one write at (639,479), `done` in cycle 5.
  - Without `BRUSH_CLIP_EN`: 4 writes, including (640,479) and (639,480).
